// File: rtl/wb_stream_mem_writer.sv
// Stream-to-memory DMA. Words arriving on a valid/ready stream are buffered
// in a first-word-fall-through FIFO and written to Wishbone memory as
// incrementing bursts. A small Wishbone slave holds the job configuration
// and the status flags.
module wb_stream_mem_writer #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // stream sink
    input  logic [WB_DW-1:0]     stream_s_data_i,
    input  logic                 stream_s_valid_i,
    output logic                 stream_s_ready_o,
    // memory master
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    // config slave
    input  logic [WB_AW-1:0]     wbs_adr_i,
    input  logic [WB_DW-1:0]     wbs_dat_i,
    input  logic [WB_DW/8-1:0]   wbs_sel_i,
    input  logic                 wbs_we_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic [2:0]           wbs_cti_i,
    input  logic [1:0]           wbs_bte_i,
    output logic [WB_DW-1:0]     wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o,
    output logic                 wbs_rty_o,
    output logic                 irq_o
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
    state_t state, state_nxt;

    // ---------------- FIFO ----------------
    logic [WB_DW-1:0]   fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_count;
    logic               fifo_full, push, pop, rdy_en;

    // rdy_en keeps ready low while in reset and for the release edge
    assign fifo_full        = (fifo_count == (FIFO_AW+1)'(DEPTH));
    assign stream_s_ready_o = rdy_en & ~fifo_full;
    assign push             = stream_s_valid_i & stream_s_ready_o;
    assign pop              = (state == S_BURST) & wbm_ack_i & ~wbm_err_i;

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= stream_s_data_i;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rdy_en     <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + (FIFO_AW)'(1);
            if (pop)  rd_ptr <= rd_ptr + (FIFO_AW)'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (FIFO_AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIFO_AW+1)'(1);
                default: ;
            endcase
        end
    end

    // ---------------- config slave ----------------
    logic [WB_AW-1:0] start_addr;
    logic [WB_DW-1:0] buf_size, burst_size, rd_data;
    logic             st_done, st_err, busy, wbs_req, wbs_wr, start;
    logic [2:0]       reg_idx;

    assign wbs_req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wbs_wr  = wbs_req & wbs_we_i;
    assign reg_idx = wbs_adr_i[4:2];
    assign busy    = (state == S_WAIT) | (state == S_BURST);
    assign start   = wbs_wr & (reg_idx == 3'd0) & wbs_dat_i[0] & (state == S_IDLE);
    assign wbs_err_o = 1'b0;
    assign wbs_rty_o = 1'b0;
    assign irq_o     = st_done | st_err;

    // register read mux; offsets past STATUS read as zero
    always_comb begin
        rd_data = '0;
        case (reg_idx)
            3'd0:    rd_data[0]   = busy;
            3'd1:    rd_data      = WB_DW'(start_addr);
            3'd2:    rd_data      = buf_size;
            3'd3:    rd_data      = burst_size;
            3'd4:    rd_data[2:0] = {st_err, st_done, busy};
            default: ;
        endcase
    end

    // single-wait-state slave; job parameters frozen while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            start_addr <= '0;
            buf_size   <= '0;
            burst_size <= '0;
        end else begin
            wbs_ack_o <= wbs_req;
            wbs_dat_o <= wbs_req ? rd_data : '0;
            if (wbs_wr && !busy) begin
                case (reg_idx)
                    3'd1:    start_addr <= wbs_dat_i[WB_AW-1:0];
                    3'd2:    buf_size   <= wbs_dat_i;
                    3'd3:    burst_size <= wbs_dat_i;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- job datapath ----------------
    logic [WB_AW-1:0] adr_q;
    logic [WB_DW-1:0] remaining, len_q, beats_left, eff_burst, len_nxt, total_words;
    logic             wait_go, last_beat;

    assign total_words = buf_size >> 2;
    assign wait_go     = (WB_DW'(fifo_count) >= len_nxt);
    assign last_beat   = (beats_left == (WB_DW)'(1));

    // burst length clamped to 1..MAX_BURST_LEN so a bad setting cannot
    // ask for more words than the FIFO can ever hold
    always_comb begin
        eff_burst = burst_size;
        if (burst_size == '0)
            eff_burst = (WB_DW)'(1);
        else if (burst_size > (WB_DW)'(MAX_BURST_LEN))
            eff_burst = (WB_DW)'(MAX_BURST_LEN);
        len_nxt = (eff_burst < remaining) ? eff_burst : remaining;
    end

    // address/count tracking and sticky status flags (set wins over W1C)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q      <= '0;
            remaining  <= '0;
            len_q      <= '0;
            beats_left <= '0;
            st_done    <= 1'b0;
            st_err     <= 1'b0;
        end else begin
            if (start) begin
                adr_q     <= start_addr;
                remaining <= total_words;
            end
            if (state == S_WAIT && wait_go) begin
                len_q      <= len_nxt;
                beats_left <= len_nxt;
            end
            if (pop) begin
                adr_q      <= adr_q + (WB_AW)'(4);
                remaining  <= remaining - (WB_DW)'(1);
                beats_left <= beats_left - (WB_DW)'(1);
            end
            if (wbs_wr && reg_idx == 3'd4) begin
                if (wbs_dat_i[1]) st_done <= 1'b0;
                if (wbs_dat_i[2]) st_err  <= 1'b0;
            end
            if (state == S_DONE) st_done <= 1'b1;
            if (state == S_BURST && wbm_err_i) st_err <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next state and master bus outputs
    always_comb begin
        state_nxt = state;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = '0;
        wbm_cti_o = 3'b000;
        wbm_dat_o = '0;
        case (state)
            S_IDLE:  if (start) state_nxt = (total_words == '0) ? S_DONE : S_WAIT;
            S_WAIT:  if (wait_go) state_nxt = S_BURST;
            S_BURST: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_sel_o = '1;
                wbm_dat_o = fifo_mem[rd_ptr];
                if (len_q == (WB_DW)'(1)) wbm_cti_o = 3'b000;
                else if (last_beat)       wbm_cti_o = 3'b111;
                else                      wbm_cti_o = 3'b010;
                if (wbm_err_i)
                    state_nxt = S_IDLE;
                else if (wbm_ack_i && last_beat)
                    state_nxt = (remaining == (WB_DW)'(1)) ? S_DONE : S_WAIT;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wbm_adr_o = adr_q;
    assign wbm_bte_o = 2'b00;

    logic unused_inputs;
    assign unused_inputs = ^{wbm_dat_i, wbm_rty_i, wbs_sel_i, wbs_cti_i, wbs_bte_i,
                             wbs_adr_i[WB_AW-1:5], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_wb_stream_mem_writer.sv
// Directed bench for wb_stream_mem_writer: register vectors from a table,
// then hand-written DMA jobs checked against a simple memory/burst model.
module tb_wb_stream_mem_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data;
    logic        s_valid;
    logic        stream_s_ready_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] s_adr, s_dat;
    logic        s_we, s_cyc, s_stb;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o, irq_o;

    always #5 clk = ~clk;

    wb_stream_mem_writer dut (
        .clk(clk), .rst_n(rst_n),
        .stream_s_data_i(s_data), .stream_s_valid_i(s_valid), .stream_s_ready_o(stream_s_ready_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_dat_i(32'h0), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(1'b0),
        .wbs_adr_i(s_adr), .wbs_dat_i(s_dat), .wbs_sel_i(4'hF), .wbs_we_i(s_we),
        .wbs_cyc_i(s_cyc), .wbs_stb_i(s_stb), .wbs_cti_i(3'b000), .wbs_bte_i(2'b00),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
        .irq_o(irq_o)
    );

    // ---------------- memory slave model ----------------
    int          acc_cnt, ack_cnt, log_n, starts, bad_starts, bad_beats, avail_prev, exp_len;
    int          job_words, job_burst, job_ack_base, err_base;
    logic        err_arm = 1'b0;
    logic        cyc_last;
    logic [31:0] mem_m [0:2047];
    logic [2:0]  cti_log [0:255];
    logic [31:0] adr_log [0:255];
    logic [31:0] exp_data [0:63];

    assign wbm_err_i = err_arm && wbm_cyc_o && wbm_stb_o && ((ack_cnt - err_base) == 2);
    assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !wbm_err_i;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= 0; ack_cnt <= 0; log_n <= 0; bad_beats <= 0;
        end else begin
            if (s_valid && stream_s_ready_o) acc_cnt <= acc_cnt + 1;
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                ack_cnt <= ack_cnt + 1;
                mem_m[wbm_adr_o[12:2]] <= wbm_dat_o;
                if (log_n < 256) begin
                    cti_log[log_n] <= wbm_cti_o;
                    adr_log[log_n] <= wbm_adr_o;
                end
                log_n <= log_n + 1;
                if (!wbm_we_o || wbm_sel_o != 4'hF || wbm_bte_o != 2'b00) bad_beats <= bad_beats + 1;
            end
        end
    end

    // a burst may only start once the words it needs were already buffered
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starts <= 0; bad_starts <= 0; cyc_last <= 1'b0; avail_prev <= 0;
        end else begin
            if (wbm_cyc_o && !cyc_last) begin
                starts <= starts + 1;
                exp_len = job_words - (ack_cnt - job_ack_base);
                if (job_burst < exp_len) exp_len = job_burst;
                if (avail_prev < exp_len) bad_starts <= bad_starts + 1;
            end
            cyc_last   <= wbm_cyc_o;
            avail_prev <= acc_cnt - ack_cnt;
        end
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_rw(input logic we, input logic [4:0] off, input logic [31:0] wd,
                         output logic [31:0] rd);
        int g = 0;
        @(negedge clk);
        s_adr = {27'h0, off}; s_dat = wd; s_we = we; s_cyc = 1'b1; s_stb = 1'b1;
        do begin
            @(negedge clk);
            g++;
        end while (!wbs_ack_o && g < 20);
        rd = wbs_dat_o;
        if (!wbs_ack_o) check("wbs_ack_timeout", {31'h0, wbs_ack_o}, 32'h1);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    endtask

    // drive n words of exp_data, valid asserted on rate% of cycles
    task automatic push_words(input int n, input int rate);
        int i = 0;
        int g = 0;
        while (i < n && g < 5000) begin
            @(negedge clk);
            g++;
            if (int'($urandom_range(99)) < rate) begin
                s_valid = 1'b1;
                s_data  = exp_data[i];
                if (stream_s_ready_o) i++;
            end else begin
                s_valid = 1'b0;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        if (i < n) check("push_timeout", i, n);
    endtask

    task automatic wait_done(input string tag, output logic [31:0] st);
        int g = 0;
        do begin
            wb_rw(1'b0, 5'h10, 32'h0, st);
            g++;
        end while (st[2:1] == 2'b00 && g < 200);
        if (st[2:1] == 2'b00) check({tag, "_done_timeout"}, st, 32'h2);
    endtask

    // full job: configure, enable, stream, then compare memory and beat log
    task automatic run_job(input logic [31:0] start, input int bufb, input int burst,
                           input int rate, input bit idle_chk, input string tag);
        logic [31:0] rd;
        logic [2:0]  ecti;
        int words, base_log, base_ack, base_st, rem, idx, len, nb, nbad;
        words = bufb / 4;
        wb_rw(1'b1, 5'h04, start, rd);
        wb_rw(1'b1, 5'h08, bufb, rd);
        wb_rw(1'b1, 5'h0C, burst, rd);
        base_log = log_n; base_ack = ack_cnt; base_st = starts;
        job_words = words; job_burst = burst; job_ack_base = ack_cnt;
        wb_rw(1'b1, 5'h00, 32'h1, rd);
        if (idle_chk) begin
            nbad = 0;
            repeat (20) begin
                @(negedge clk);
                if (wbm_cyc_o) nbad++;
            end
            check({tag, "_no_cyc_while_empty"}, nbad, 0);
        end
        push_words(words, rate);
        wait_done(tag, rd);
        check({tag, "_status"}, rd, 32'h2);
        check({tag, "_irq"}, irq_o, 1'b1);
        check({tag, "_acks"}, ack_cnt - base_ack, words);
        check({tag, "_adr_end"}, wbm_adr_o, start + bufb);
        for (int i = 0; i < words; i++)
            check($sformatf("%s_mem%0d", tag, i), mem_m[(start >> 2) + i], exp_data[i]);
        rem = words; idx = 0; nb = 0;
        while (rem > 0) begin
            len = (burst < rem) ? burst : rem;
            nb++;
            for (int b = 0; b < len; b++) begin
                ecti = (len == 1) ? 3'b000 : ((b == len - 1) ? 3'b111 : 3'b010);
                check($sformatf("%s_cti%0d", tag, idx), cti_log[base_log + idx], ecti);
                check($sformatf("%s_adr%0d", tag, idx), adr_log[base_log + idx], start + 4 * idx);
                idx++;
            end
            rem -= len;
        end
        check({tag, "_bursts"}, starts - base_st, nb);
        wb_rw(1'b1, 5'h10, 32'h2, rd);
        wb_rw(1'b0, 5'h10, 32'h0, rd);
        check({tag, "_status_clr"}, rd, 32'h0);
        check({tag, "_irq_clr"}, irq_o, 1'b0);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  off;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [12];

    initial begin
        logic [31:0] rd;
        int g, base, base_st;
        s_data = 0; s_valid = 0; s_adr = 0; s_dat = 0; s_we = 0; s_cyc = 0; s_stb = 0;
        job_words = 0; job_burst = 1; job_ack_base = 0; err_base = 0;

        vecs[0]  = '{1'b0, 5'h00, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'h04, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 5'h10, 32'h0,        32'h0};
        vecs[3]  = '{1'b1, 5'h04, 32'h0000_0040, 32'h0};
        vecs[4]  = '{1'b0, 5'h04, 32'h0,        32'h0000_0040};
        vecs[5]  = '{1'b1, 5'h08, 32'd64,       32'h0};
        vecs[6]  = '{1'b0, 5'h08, 32'h0,        32'd64};
        vecs[7]  = '{1'b1, 5'h0C, 32'd8,        32'h0};
        vecs[8]  = '{1'b0, 5'h0C, 32'h0,        32'd8};
        vecs[9]  = '{1'b0, 5'h14, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 5'h1C, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 5'h00, 32'h0,        32'h0};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_cyc", wbm_cyc_o, 1'b0);
        check("rst_ready", stream_s_ready_o, 1'b0);
        check("rst_irq", irq_o, 1'b0);
        check("rst_wbs_ack", wbs_ack_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", stream_s_ready_o, 1'b1);

        for (int i = 0; i < 12; i++) begin
            wb_rw(vecs[i].we, vecs[i].off, vecs[i].wdat, rd);
            if (!vecs[i].we) check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // two 8-beat bursts, continuous stream
        for (int i = 0; i < 16; i++) exp_data[i] = 32'h100 + i;
        run_job(32'h40, 64, 8, 100, 1'b0, "t1");

        // 10 words as 4,4,2 then 9 words as 4,4,1 (single-beat cti=000)
        for (int i = 0; i < 10; i++) exp_data[i] = 32'h2000 + i;
        run_job(32'h200, 40, 4, 100, 1'b0, "t2");
        for (int i = 0; i < 9; i++) exp_data[i] = 32'h3000 + i;
        run_job(32'h300, 36, 4, 100, 1'b0, "t2b");

        // sparse stream with random data
        for (int i = 0; i < 32; i++) exp_data[i] = $urandom;
        run_job(32'h400, 128, 8, 25, 1'b0, "t3");

        // zero-length job completes with no bus cycle
        base_st = starts;
        wb_rw(1'b1, 5'h08, 32'h0, rd);
        wb_rw(1'b1, 5'h00, 32'h1, rd);
        wb_rw(1'b0, 5'h10, 32'h0, rd);
        check("t0_status", rd, 32'h2);
        check("t0_no_burst", starts - base_st, 0);
        wb_rw(1'b1, 5'h10, 32'h2, rd);

        // prefill to full, then one 32-beat burst
        for (int i = 0; i < 32; i++) exp_data[i] = 32'h4000 + i;
        base = acc_cnt;
        push_words(32, 100);
        check("t4_ready_full", stream_s_ready_o, 1'b0);
        s_valid = 1'b1; s_data = 32'hDEAD;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        check("t4_33rd_stalled", acc_cnt - base, 32);
        wb_rw(1'b1, 5'h04, 32'h800, rd);
        wb_rw(1'b1, 5'h08, 32'd128, rd);
        wb_rw(1'b1, 5'h0C, 32'd32, rd);
        base = log_n; base_st = starts;
        job_words = 32; job_burst = 32; job_ack_base = ack_cnt;
        wb_rw(1'b1, 5'h00, 32'h1, rd);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(wbm_cyc_o && wbm_ack_i) && g < 100);
        check("t4_ready_at_first_ack", stream_s_ready_o, 1'b0);
        @(negedge clk);
        check("t4_ready_after_ack", stream_s_ready_o, 1'b1);
        wait_done("t4", rd);
        check("t4_status", rd, 32'h2);
        for (int i = 0; i < 32; i++) check($sformatf("t4_mem%0d", i), mem_m[(32'h800 >> 2) + i], exp_data[i]);
        check("t4_cti_first", cti_log[base], 3'b010);
        check("t4_cti_last", cti_log[base + 31], 3'b111);
        check("t4_bursts", starts - base_st, 1);
        wb_rw(1'b1, 5'h10, 32'h2, rd);

        // bus error on beat 3; busy locks the config registers
        wb_rw(1'b1, 5'h04, 32'hC00, rd);
        wb_rw(1'b1, 5'h08, 32'd32, rd);
        wb_rw(1'b1, 5'h0C, 32'd8, rd);
        job_words = 8; job_burst = 8; job_ack_base = ack_cnt;
        err_base = ack_cnt; err_arm = 1'b1;
        wb_rw(1'b1, 5'h00, 32'h1, rd);
        wb_rw(1'b1, 5'h04, 32'hFFF0, rd);
        wb_rw(1'b0, 5'h04, 32'h0, rd);
        check("t5_start_locked", rd, 32'hC00);
        wb_rw(1'b0, 5'h00, 32'h0, rd);
        check("t5_enable_reads_busy", rd, 32'h1);
        for (int i = 0; i < 8; i++) exp_data[i] = 32'h5000 + i;
        push_words(8, 100);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!wbm_err_i && g < 100);
        check("t5_err_seen", wbm_err_i, 1'b1);
        @(negedge clk);
        check("t5_cyc_drop", wbm_cyc_o, 1'b0);
        err_arm = 1'b0;
        check("t5_acks", ack_cnt - err_base, 2);
        wb_rw(1'b0, 5'h10, 32'h0, rd);
        check("t5_status", rd, 32'h4);
        check("t5_irq", irq_o, 1'b1);
        wb_rw(1'b1, 5'h10, 32'h4, rd);
        wb_rw(1'b0, 5'h10, 32'h0, rd);
        check("t5_status_clr", rd, 32'h0);
        check("t5_irq_clr", irq_o, 1'b0);

        // reset in the middle of a burst
        wb_rw(1'b1, 5'h04, 32'h1000, rd);
        wb_rw(1'b1, 5'h08, 32'd64, rd);
        wb_rw(1'b1, 5'h0C, 32'd16, rd);
        job_words = 16; job_burst = 16; job_ack_base = ack_cnt;
        base = ack_cnt;
        wb_rw(1'b1, 5'h00, 32'h1, rd);
        for (int i = 0; i < 16; i++) exp_data[i] = 32'h6000 + i;
        push_words(16, 100);
        g = 0;
        while ((ack_cnt - base) < 4 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("t6_midburst", wbm_cyc_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_cyc", wbm_cyc_o, 1'b0);
        check("t6_rst_stb", wbm_stb_o, 1'b0);
        check("t6_rst_wbs_ack", wbs_ack_o, 1'b0);
        check("t6_rst_irq", irq_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after_rst", stream_s_ready_o, 1'b1);
        wb_rw(1'b0, 5'h10, 32'h0, rd);
        check("t6_status", rd, 32'h0);
        wb_rw(1'b0, 5'h04, 32'h0, rd);
        check("t6_start_cleared", rd, 32'h0);
        for (int i = 0; i < 4; i++) exp_data[i] = 32'h7000 + i;
        run_job(32'h1400, 16, 4, 100, 1'b1, "t6b");

        check("no_early_burst", bad_starts, 0);
        check("beat_attrs", bad_beats, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
